// File: rtl/rvlab_rstmgr.sv
`default_nettype none
// ============================================================================
//  Module      : rvlab_rstmgr
//  Description : Reset sequencer behind the clock manager. It synchronises
//                MMCM lock, debounces the board button, accepts a software
//                reset and releases peripheral then core reset in order.
//                It also keeps a sticky reset-cause register.
//  Revision    : 1.0 - initial release
// ============================================================================
module rvlab_rstmgr #(
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int STRETCH_CYCLES    = 32,
    parameter int CORE_DELAY_CYCLES = 8,
    parameter int BTN_ACTIVE_LOW    = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       locked_i,
    input  logic       btn_i,
    input  logic       sw_rst_req_i,
    input  logic       cause_clr_i,
    output logic       periph_rst_o,
    output logic       sys_rst_o,
    output logic       ready_o,
    output logic [3:0] rst_cause_o
);

    localparam int c_MAX_AB     = (DEBOUNCE_CYCLES > STRETCH_CYCLES) ? DEBOUNCE_CYCLES : STRETCH_CYCLES;
    localparam int c_MAX_CYCLES = (c_MAX_AB > CORE_DELAY_CYCLES) ? c_MAX_AB : CORE_DELAY_CYCLES;
    localparam int c_CW         = $clog2(c_MAX_CYCLES + 1);

    localparam logic [c_CW-1:0] c_ONE           = c_CW'(1);
    localparam logic [c_CW-1:0] c_DEB_LAST      = c_CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CW-1:0] c_STRETCH_LAST  = c_CW'(STRETCH_CYCLES - 1);
    localparam logic [c_CW-1:0] c_CORE_DLY_LAST = c_CW'(CORE_DELAY_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HOLD       = 2'd0,
        S_STRETCH    = 2'd1,
        S_REL_PERIPH = 2'd2,
        S_RUN        = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers; the button is normalised so 1 means pressed
    // ------------------------------------------------------------------
    logic                   w_btn_norm;
    logic [SYNC_STAGES-1:0] r_lock_sync;
    logic [SYNC_STAGES-1:0] r_btn_sync;
    logic                   w_lock_s;
    logic                   w_btn_s;

    assign w_btn_norm = (BTN_ACTIVE_LOW != 0) ? ~btn_i : btn_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lock_sync <= '0;
            r_btn_sync  <= '0;
        end else begin
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], locked_i};
            r_btn_sync  <= {r_btn_sync[SYNC_STAGES-2:0], w_btn_norm};
        end
    end

    assign w_lock_s = r_lock_sync[SYNC_STAGES-1];
    assign w_btn_s  = r_btn_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Button debouncer
    // ------------------------------------------------------------------
    logic            r_btn_db;
    logic [c_CW-1:0] r_db_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_btn_db <= 1'b0;
            r_db_cnt <= '0;
        end else if (w_btn_s == r_btn_db) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == c_DEB_LAST) begin
            r_btn_db <= w_btn_s;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + c_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    logic            w_src;
    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_cnt_nxt;
    logic            r_periph_rst;
    logic            r_sys_rst;
    logic            r_ready;
    logic            w_periph_rst_nxt;
    logic            w_sys_rst_nxt;
    logic            w_ready_nxt;

    assign w_src = ~w_lock_s | r_btn_db | sw_rst_req_i;

    // An active source always wins over a terminal count in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_HOLD: begin
                w_cnt_nxt = '0;
                if (!w_src) begin
                    w_state_nxt = S_STRETCH;
                end
            end
            S_STRETCH: begin
                if (w_src) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_STRETCH_LAST) begin
                    w_state_nxt = S_REL_PERIPH;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end
            S_REL_PERIPH: begin
                if (w_src) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CORE_DLY_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end
            S_RUN: begin
                w_cnt_nxt = '0;
                if (w_src) begin
                    w_state_nxt = S_HOLD;
                end
            end
            default: begin
                w_state_nxt = S_HOLD;
                w_cnt_nxt   = '0;
            end
        endcase

        w_periph_rst_nxt = !((w_state_nxt == S_REL_PERIPH) || (w_state_nxt == S_RUN));
        w_sys_rst_nxt    = (w_state_nxt != S_RUN);
        w_ready_nxt      = (w_state_nxt == S_RUN);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_HOLD;
            r_cnt        <= '0;
            r_periph_rst <= 1'b1;
            r_sys_rst    <= 1'b1;
            r_ready      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_periph_rst <= w_periph_rst_nxt;
            r_sys_rst    <= w_sys_rst_nxt;
            r_ready      <= w_ready_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Sticky reset cause; a set in the same cycle as a clear survives it
    // ------------------------------------------------------------------
    logic       w_enter_hold;
    logic [3:0] w_cause_set;
    logic [3:0] r_cause;

    assign w_enter_hold = (r_state != S_HOLD) && w_src;
    assign w_cause_set  = w_enter_hold ? {sw_rst_req_i, r_btn_db, ~w_lock_s, 1'b0} : 4'b0000;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cause <= 4'b0001;
        end else begin
            r_cause <= (cause_clr_i ? 4'b0000 : r_cause) | w_cause_set;
        end
    end

    assign periph_rst_o = r_periph_rst;
    assign sys_rst_o    = r_sys_rst;
    assign ready_o      = r_ready;
    assign rst_cause_o  = r_cause;

endmodule
`default_nettype wire
